// File: rtl/spram_mask_ctrl_if.sv
// Request, response and macro-pin bundle for spram_mask_ctrl.
// master = requester/consumer plus macro side, slave = the controller.
interface spram_mask_ctrl_if #(
  parameter int WIDTH            = 16,
  parameter int ADDR_WIDTH       = 4,
  parameter int NUM_BYTE_ENABLES = 16
);
  logic                        wr_valid;
  logic                        wr_ready;
  logic [ADDR_WIDTH-1:0]       wr_addr;
  logic [WIDTH-1:0]            wr_data;
  logic [NUM_BYTE_ENABLES-1:0] wr_be;
  logic                        rd_valid;
  logic                        rd_ready;
  logic [ADDR_WIDTH-1:0]       rd_addr;
  logic                        rsp_valid;
  logic                        rsp_ready;
  logic [WIDTH-1:0]            rsp_data;
  logic                        CSN;
  logic                        WEN;
  logic [ADDR_WIDTH-1:0]       A;
  logic [WIDTH-1:0]            D;
  logic [NUM_BYTE_ENABLES-1:0] MASKN;
  logic [WIDTH-1:0]            Q;

  modport master (
    output wr_valid, wr_addr, wr_data, wr_be, rd_valid, rd_addr, rsp_ready, Q,
    input  wr_ready, rd_ready, rsp_valid, rsp_data, CSN, WEN, A, D, MASKN
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data, wr_be, rd_valid, rd_addr, rsp_ready, Q,
    output wr_ready, rd_ready, rsp_valid, rsp_data, CSN, WEN, A, D, MASKN
  );
endinterface

// File: rtl/spram_mask_ctrl.sv
// Front-end for a single-port masked SRAM macro: arbitrates write/read streams onto
// the one port, absorbs the 1-cycle read latency and returns data via a 2-entry FIFO.
module spram_mask_ctrl #(
  parameter int WORDS            = 16,
  parameter int WIDTH            = 16,
  parameter int ADDR_WIDTH       = 4,
  parameter int NUM_BYTE_ENABLES = 16
) (
  input logic              i_clk,
  input logic              i_rst,
  spram_mask_ctrl_if.slave bus
);
  typedef enum logic {GNT_RD = 1'b0, GNT_WR = 1'b1} grant_t;

  localparam logic [ADDR_WIDTH:0] WORDS_L = (ADDR_WIDTH + 1)'(WORDS);

  grant_t           r_last_grant;
  logic             r_inflight;
  logic             r_inflight_oor;
  logic [WIDTH-1:0] r_fifo [2];
  logic             r_wptr;
  logic             r_rptr;
  logic [1:0]       r_occ;

  logic       w_pop;
  logic [2:0] w_outstanding;
  logic       w_rd_credit;
  logic       w_gnt_wr;
  logic       w_gnt_rd;
  logic       w_wr_oor;
  logic       w_rd_oor;
  logic       w_wr_access;

  assign bus.rsp_valid = !i_rst && (r_occ != 2'd0);
  assign bus.rsp_data  = r_fifo[r_rptr];
  assign w_pop         = bus.rsp_valid && bus.rsp_ready;

  // Reads in flight or queued, less the one leaving now; keeps the FIFO from overflowing.
  assign w_outstanding = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_rd_credit   = w_outstanding < 3'd2;

  assign w_gnt_wr = !i_rst && bus.wr_valid &&
                    (!(bus.rd_valid && w_rd_credit) || (r_last_grant == GNT_RD));
  assign w_gnt_rd = !i_rst && bus.rd_valid && w_rd_credit &&
                    (!bus.wr_valid || (r_last_grant == GNT_WR));

  assign bus.wr_ready = w_gnt_wr;
  assign bus.rd_ready = w_gnt_rd;

  assign w_wr_oor    = !({1'b0, bus.wr_addr} < WORDS_L);
  assign w_rd_oor    = !({1'b0, bus.rd_addr} < WORDS_L);
  assign w_wr_access = (bus.wr_be != '0) && !w_wr_oor;

  always_comb begin
    bus.CSN   = 1'b1;
    bus.WEN   = 1'b1;
    bus.A     = '0;
    bus.D     = '0;
    bus.MASKN = '1;
    if (w_gnt_wr) begin
      bus.CSN   = !w_wr_access;
      bus.WEN   = 1'b0;
      bus.A     = bus.wr_addr;
      bus.D     = bus.wr_data;
      bus.MASKN = ~bus.wr_be;
    end else if (w_gnt_rd) begin
      bus.CSN = w_rd_oor;
      bus.A   = bus.rd_addr;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_last_grant   <= GNT_RD;
      r_inflight     <= 1'b0;
      r_inflight_oor <= 1'b0;
      r_wptr         <= 1'b0;
      r_rptr         <= 1'b0;
      r_occ          <= 2'd0;
    end else begin
      if (w_gnt_wr) begin
        r_last_grant <= GNT_WR;
      end else if (w_gnt_rd) begin
        r_last_grant <= GNT_RD;
      end
      r_inflight     <= w_gnt_rd;
      r_inflight_oor <= w_gnt_rd && w_rd_oor;
      if (r_inflight) begin
        r_fifo[r_wptr] <= r_inflight_oor ? '0 : bus.Q;
        r_wptr         <= !r_wptr;
      end
      if (w_pop) begin
        r_rptr <= !r_rptr;
      end
      r_occ <= r_occ + {1'b0, r_inflight} - {1'b0, w_pop};
    end
  end

  a_no_overflow: assert property (@(posedge i_clk) disable iff (i_rst)
    !(r_inflight && (r_occ == 2'd2) && !w_pop));

endmodule
